regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Sequential reader that walks every entry of the CPU register file through one of its asynchronous read ports and streams each `(address, data)` pair out over a valid/ready handshake. It also accumulates an XOR checksum of all transferred words. It sits beside the register file in the CA2 datapath and gives the testbench and debug logic a cycle-accurate, back-pressurable dump of architectural state. It never writes the register file.

## Interface
Parameters:
- `ADDR_W`, 5, register index width.
- `DATA_W`, 32, register data width.
- `NUM_REGS`, 32, entries dumped, indices 0..NUM_REGS-1; must be ≤ 2^ADDR_W.

Ports (one clock; reset is asynchronous and active-high):
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: request a dump; sampled only in IDLE.
- `RR` out ADDR_W: read address to the register-file read port; equals internal index `idx`.
- `RD` in DATA_W: combinational read data returned for `RR`.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: consumer accepts word.
- `out_addr` out ADDR_W: index of the presented word.
- `out_data` out DATA_W: captured register value.
- `out_last` out 1: presented word is index NUM_REGS-1.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse after the last handshake.
- `checksum` out DATA_W: XOR of all words handshaken in the current or most recent dump; held until the next `start`.

## Operation
- States: IDLE, FETCH, SEND, FIN.
- IDLE → FETCH on `start`: `idx` ← 0, `checksum` ← 0.
- FETCH (one cycle): `RR = idx`; at the edge, `out_data` ← `RD`, `out_addr` ← `idx`, `out_last` ← (`idx == NUM_REGS-1`), `out_valid` ← 1; go to SEND.
- SEND: hold `out_valid`, `out_data`, `out_addr`, and `out_last` stable until `out_valid & out_ready`. On that handshake:
  - `checksum` ← `checksum ^ out_data`.
  - `out_valid` ← 0.
  - If `out_last`, go to FIN.
  - Otherwise `idx` ← `idx+1` and go to FETCH.
- FIN (one cycle): `done` = 1 (registered); go to IDLE.
- `start` is ignored outside IDLE and never restarts or extends a dump.
- Coherency: each word is the register value at the FETCH edge. Writes to an index after its FETCH are not reflected. Writes to later indices before their FETCH are reflected.
- `out_ready` asserted without `out_valid` has no effect.
- Register 0 is dumped like any other index; its value is whatever the register file returns.
- `RR` is driven to `idx` in every state. `idx` stays at its last value in FIN/IDLE until the next `start`.

## Timing
- Reset values: state IDLE, `idx`/`RR` 0, `out_valid` 0, `out_addr` 0, `out_data` 0, `out_last` 0, `busy` 0, `done` 0, `checksum` 0.
- All outputs are registered except `RR` (decoded from `idx`) and `busy` (decoded from state).
- Per-word cost: 1 FETCH cycle + ≥1 SEND cycle. Minimum is 2 cycles/word.
- With `out_ready` held high and `start` sampled at edge e0:
  - Word k handshakes at edge e0+2k+2.
  - Last handshake is at e0+2·NUM_REGS (e0+64 by default).
  - `done` is high for the cycle after e0+64.
  - IDLE again at e0+65.
  - `busy` is high from after e0 through the FIN cycle.
- Back-pressure: each cycle `out_ready` is low in SEND adds exactly one cycle. No word is dropped or duplicated.
- `RST` mid-dump: immediately returns to IDLE with reset values. No `done` pulse, and the checksum is cleared. A dump after reset starts from index 0.
- `start` and the FIN cycle coinciding: `start` is ignored. A new dump requires `start` while in IDLE.

## Structure
- Package `regfile_dump_pkg`: state enum (IDLE, FETCH, SEND, FIN) and default width constants `RF_ADDR_W=5`, `RF_DATA_W=32`, `RF_NUM_REGS=32`.
- Single module with no sub-modules. The bench instantiates the existing register file and connects `RR`/`RD` to its port-1 pair.

## Test plan
- Full dump, ready always high. Register file loaded `Regs[i]=i` except `Regs[5]=0xDEADBEEF`. Required: 32 handshakes with `out_addr` 0..31 in order, `out_last` only at 31, `done` at cycle e0+65 relative to `start`, `checksum=0xDEADBEEA`.
- Random back-pressure (`out_ready` ~50%). Required: same word sequence and checksum; `out_data`/`out_addr` are stable whenever `out_valid & !out_ready`; total cycles = 64 + count of stalled SEND cycles.
- `start` pulsed repeatedly during a dump and in the FIN cycle. Required: exactly one dump and one `done`; the next dump begins only after `start` in IDLE.
- `RST` asserted mid-dump at index 10. Required: `out_valid`, `busy`, and `checksum` drop to 0 asynchronously, with no `done`. A new `start` streams from index 0.
- Concurrent write: write 0x12345678 to x3 during the SEND of index 2, and to x1 during the SEND of index 2. Required: dumped x3 = 0x12345678; dumped x1 keeps its old value.
- Reset values: after `RST`, with no `start`, check every output is at its reset value for 10 cycles with `out_ready` toggling.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared types and default widths for the register-file dump reader.
package regfile_dump_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks every register-file entry through one async read port and streams
// (address, data) pairs over valid/ready, accumulating an XOR checksum.
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic [ADDR_W-1:0] RR,
  input  logic [DATA_W-1:0] RD,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] idx_q;
  logic              handshake;

  // The read port always looks at the current index; busy is a state decode.
  assign RR        = idx_q;
  assign busy      = (state_q != IDLE);
  assign handshake = (state_q == SEND) && out_valid && out_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset is asynchronous and active-high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; start only matters in IDLE, so FIN ignores it.
  // NOTE: state_d gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = SEND;
      SEND:    if (handshake) state_d = out_last ? FIN : FETCH;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture the word at FETCH, hold it through SEND, fold it into
  // the checksum on handshake, and pulse done on the cycle spent in FIN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      done <= handshake && out_last;
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q    <= '0;
            checksum <= '0;
          end
        end
        FETCH: begin
          out_data  <= RD;
          out_addr  <= idx_q;
          out_last  <= (idx_q == LAST_IDX);
          out_valid <= 1'b1;
        end
        SEND: begin
          if (handshake) begin
            checksum  <= checksum ^ out_data;
            out_valid <= 1'b0;
            if (!out_last) idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a vector table for the first
// cycles of a dump, then randomized back-pressure dumps scored against a
// word-list model, plus start-spam, concurrent-write and mid-dump reset runs.
module tb_regfile_dump_reader;
  import regfile_dump_pkg::*;

  localparam int AW = RF_ADDR_W;
  localparam int DW = RF_DATA_W;
  localparam int NR = RF_NUM_REGS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          out_ready;
  logic [AW-1:0] rr;
  logic [DW-1:0] rd;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  // Behavioural register file: asynchronous read port.
  logic [DW-1:0] regs      [NR];
  // Words the consumer must receive, in index order.
  logic [DW-1:0] exp_words [NR];

  int n_checks = 0;
  int n_fail   = 0;

  // Modes for do_dump.
  int ready_pct = 100;
  bit spam_start = 1'b0;
  bit wr_mode = 1'b0;

  assign rd = regs[rr];

  always #5 clk = ~clk;

  regfile_dump_reader #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .NUM_REGS(NR)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .start    (start),
    .RR       (rr),
    .RD       (rd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  typedef struct {
    logic          start;
    logic          ready;
    logic          exp_busy;
    logic          exp_valid;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_last;
    logic          exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_regs();
    for (int i = 0; i < NR; i++) regs[i] = DW'(i);
    regs[5] = 32'hDEADBEEF;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Runs one dump from a start pulse in IDLE and scores it against exp_words.
  // Word k must handshake at edge 2k+2 plus the SEND stall cycles so far.
  task automatic do_dump(input string tag);
    int            k = 0;
    int            stalls = 0;
    int            dones = 0;
    int            done_edge = -1;
    int            edge_cnt = 0;
    int            busy_bad = 0;
    int            stab_bad = 0;
    bit            prev_stall = 1'b0;
    bit            wrote = 1'b0;
    bit            hs;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;
    logic          p_last = 1'b0;
    logic [DW-1:0] cs = '0;

    start = 1'b1;
    step();              // edge e0
    start = 1'b0;
    while (edge_cnt < 1000 && !(k == NR && !busy)) begin
      if (!busy) busy_bad++;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      start = spam_start && busy;
      if (wr_mode && out_valid && out_addr == AW'(2) && !wrote) begin
        regs[3] = 32'h12345678;
        regs[1] = 32'h12345678;
        wrote = 1'b1;
      end
      if (prev_stall && (out_addr !== p_addr || out_data !== p_data || out_last !== p_last))
        stab_bad++;
      hs = out_valid && out_ready;
      if (hs) begin
        if (k >= NR) begin
          check({tag, " extra_word"}, 128'(k), 128'(NR - 1));
        end else begin
          check({tag, " hs_addr"}, 128'(out_addr), 128'(k));
          check({tag, " hs_data"}, 128'(out_data), 128'(exp_words[k]));
          check({tag, " hs_last"}, 128'(out_last), 128'(k == NR - 1));
          check({tag, " rr"}, 128'(rr), 128'(k));
          check({tag, " hs_edge"}, 128'(edge_cnt + 1), 128'(2 * k + 2 + stalls));
          cs = cs ^ exp_words[k];
        end
        k++;
      end else if (out_valid) begin
        stalls++;
      end
      prev_stall = out_valid && !out_ready;
      p_addr = out_addr;
      p_data = out_data;
      p_last = out_last;
      step();
      edge_cnt++;
      if (done) begin
        dones++;
        done_edge = edge_cnt;
      end
    end
    start = 1'b0;
    check({tag, " timeout"}, 128'(edge_cnt < 1000), 128'(1));
    check({tag, " word_count"}, 128'(k), 128'(NR));
    check({tag, " done_count"}, 128'(dones), 128'(1));
    check({tag, " done_edge"}, 128'(done_edge), 128'(2 * NR + stalls));
    check({tag, " idle_edge"}, 128'(edge_cnt), 128'(2 * NR + 1 + stalls));
    check({tag, " busy_span"}, 128'(busy_bad), 128'(0));
    check({tag, " stable"}, 128'(stab_bad), 128'(0));
    check({tag, " checksum"}, 128'(checksum), 128'(cs));
    check({tag, " end_valid"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    int            n;
    int            extra_done;
    logic [DW-1:0] cs_pre;

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    load_regs();

    // Reset values: held for 10 cycles with out_ready toggling and no start.
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      out_ready = c[0];
      step();
      check("reset_values",
            128'({out_valid, out_addr, out_data, out_last, busy, done, checksum, rr}),
            128'(0));
    end

    // Vector table: first cycles of a dump, including a stall and an
    // ignored start while busy. Register i holds i for these indices.
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, AW'(0), DW'(0), 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, AW'(0), DW'(0), 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, AW'(0), DW'(0), 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, AW'(0), DW'(0), 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, AW'(0), DW'(0), 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, AW'(0), DW'(0), 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, AW'(1), DW'(1), 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, AW'(1), DW'(1), 1'b0, 1'b0});
    foreach (vecs[i]) begin
      start     = vecs[i].start;
      out_ready = vecs[i].ready;
      step();
      check($sformatf("vec%0d", i),
            128'({busy, out_valid, out_addr, out_data, out_last, done}),
            128'({vecs[i].exp_busy, vecs[i].exp_valid, vecs[i].exp_addr,
                  vecs[i].exp_data, vecs[i].exp_last, vecs[i].exp_done}));
    end
    start = 1'b0;
    pulse_reset();

    // Full dump with ready held high.
    load_regs();
    foreach (exp_words[i]) exp_words[i] = regs[i];
    ready_pct = 100;
    do_dump("full");
    check("full checksum_const", 128'(checksum), 128'(32'hDEADBEEA));

    // Random back-pressure.
    ready_pct = 50;
    do_dump("bp");
    check("bp checksum_const", 128'(checksum), 128'(32'hDEADBEEA));

    // start held high through the whole dump including the FIN cycle.
    ready_pct  = 70;
    spam_start = 1'b1;
    do_dump("spam");
    spam_start = 1'b0;
    extra_done = 0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      out_ready = c[0];
      step();
      if (busy) n++;
      if (done) extra_done++;
    end
    check("spam idle_after", 128'(n), 128'(0));
    check("spam no_extra_done", 128'(extra_done), 128'(0));

    // Concurrent writes during SEND of index 2: x3 is later (reflected),
    // x1 is already fetched (old value kept).
    load_regs();
    foreach (exp_words[i]) exp_words[i] = regs[i];
    exp_words[3] = 32'h12345678;
    ready_pct = 60;
    wr_mode   = 1'b1;
    do_dump("wr");
    wr_mode = 1'b0;

    // Reset mid-dump at index 10.
    load_regs();
    foreach (exp_words[i]) exp_words[i] = regs[i];
    cs_pre = '0;
    for (int i = 0; i < 10; i++) cs_pre = cs_pre ^ regs[i];
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_addr == AW'(10)) && n < 200) begin
      step();
      n++;
    end
    check("rst reach_idx10", 128'(n < 200), 128'(1));
    check("rst cs_before", 128'(checksum), 128'(cs_pre));
    #2 rst = 1'b1;
    #1;
    check("rst async_outputs",
          128'({out_valid, busy, checksum, done, out_addr, rr}), 128'(0));
    step();
    step();
    rst = 1'b0;
    extra_done = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (done || busy) extra_done++;
    end
    check("rst no_done", 128'(extra_done), 128'(0));
    ready_pct = 50;
    do_dump("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
